icache_direct_mapped: RTL and testbench
=======================================

// Module: icache_direct_mapped
// PURPOSE
//  Direct-mapped, read-only instruction cache between the CPU fetch stage and Instruction_memory.
//  Serves 32-bit instructions to the CPU on hits with zero added cycles.
//  On a miss it stalls the CPU and refills one 128-bit block (4 words) over the
//  28-bit block-address / 128-bit data memory port.
// PARAMETERS
//  INDEX_BITS  3  set-index width; SETS = 2**INDEX_BITS (default 8 lines); TAG_W = 28-INDEX_BITS
// PORTS
//  clock          in   1    single clock, all state updates on posedge
//  reset          in   1    asynchronous, active-high
//  read           in   1    CPU fetch request
//  address        in   32   CPU byte address: [1:0] ignored, [3:2] word, [3+INDEX_BITS:4] index, [31:4+INDEX_BITS] tag
//  instruction    out  32   fetched instruction, valid when read=1 and busywait=0
//  busywait       out  1    CPU stall
//  mem_read       out  1    block read request to Instruction_memory
//  mem_address    out  28   block address {tag,index} (= address[31:4])
//  mem_readdata   in   128  refill block; byte k of block at bits [8k+7:8k]
//  mem_busywait   in   1    memory busy
// BEHAVIOUR
//  Storage: per line valid bit, TAG_W-bit tag, 128-bit data. No dirty bits (read-only).
//  Hit = read & valid[index] & (tag_array[index]==tag) & state==IDLE; combinational.
//  instruction = data[index] word select: 00->[31:0], 01->[63:32], 10->[95:64], 11->[127:96].
//  busywait = read & ~hit (combinational); busywait = 0 whenever read=0.
//  FSM states IDLE, MEM_READ, UPDATE:
//   IDLE: read & miss -> MEM_READ at next posedge; latch miss tag/index into miss registers.
//   MEM_READ: mem_read=1, mem_address={miss_tag,miss_index};
//     on a posedge with mem_busywait=0 -> UPDATE; otherwise stay.
//   UPDATE: mem_read=0; at the posedge, write mem_readdata, miss_tag, and valid=1 into line miss_index -> IDLE.
//  Miss latency: the cycle after IDLE returns is a hit; busywait is held high throughout MEM_READ and UPDATE.
//  CPU holds address stable while busywait=1. The refill always targets the latched miss address.
//  An address change mid-miss does not corrupt the refill; the new address re-evaluates in IDLE.
//  Conflict: a new tag on the same index overwrites the line unconditionally.
//  Reset values (immediate, async): state=IDLE, all valid=0, mem_read=0, mem_address=0, miss regs=0.
//   instruction is driven from the array; its value is don't-care while busywait=1.
//  Reset mid-refill: abort. mem_read drops immediately, no line written, and the next fetch misses.
//  mem_readdata is ignored outside UPDATE.
// CONFIGURATION
//  ICACHE_FLUSH_EN defined: adds input port flush (1 bit).
//   flush=1 at a posedge in IDLE clears all valid bits.
//   flush in MEM_READ/UPDATE is deferred until the FSM returns to IDLE; the in-flight line is then invalidated too.
//   While flush is pending or asserted, busywait=1 if read=1.
//  ICACHE_FLUSH_EN undefined: no flush port; valid bits are cleared only by reset.
// TESTING
//  1 reset, read=1 addr 0x00000000 -> busywait=1; next cycle mem_read=1, mem_address=0x0000000;
//    after mem_busywait=0 plus UPDATE -> instruction = bytes 3..0 of block 0, busywait=0.
//  2 after test 1, addr 0x4,0x8,0xC back-to-back -> busywait=0 every cycle, mem_read stays 0, words 1..3 returned.
//  3 addr 0x00000080 (index 0, tag 1) -> miss, mem_address=0x0000008; then addr 0x0 -> miss again (eviction).
//  4 reset pulsed during MEM_READ -> mem_read=0 immediately; subsequent fetch of the same address misses.
//  5 read=0 with cold cache -> busywait=0, mem_read never asserts.
//  6 (ICACHE_FLUSH_EN) fill 0x0, pulse flush in IDLE -> next fetch of 0x0 misses and refills.

Source files
------------

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache: 4-word lines, single-block refill on a miss.
// Define ICACHE_FLUSH_EN to add a flush input that invalidates every line.
module icache_direct_mapped #(
    parameter int INDEX_BITS = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         read,
    input  logic [31:0]  address,
    output logic [31:0]  instruction,
    output logic         busywait,
    output logic         mem_read,
    output logic [27:0]  mem_address,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait
`ifdef ICACHE_FLUSH_EN
    ,
    input  logic         flush
`endif
);
    localparam int SETS  = 2 ** INDEX_BITS;
    localparam int TAG_W = 28 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;
    state_t state;

    logic [SETS-1:0]       valid;
    logic [TAG_W-1:0]      tag_array  [SETS];
    logic [127:0]          data_array [SETS];
    logic [TAG_W-1:0]      miss_tag;
    logic [INDEX_BITS-1:0] miss_index;

    logic [TAG_W-1:0]      tag;
    logic [INDEX_BITS-1:0] index;
    logic [1:0]            word;
    logic                  unused_byte_bits;

    assign tag              = address[31:4+INDEX_BITS];
    assign index            = address[3+INDEX_BITS:4];
    assign word             = address[3:2];
    assign unused_byte_bits = ^address[1:0];

    logic hit;
    logic flush_req;

`ifdef ICACHE_FLUSH_EN
    logic flush_pending;
    assign flush_req = flush | flush_pending;
`else
    assign flush_req = 1'b0;
`endif

    assign hit      = read && valid[index] && (tag_array[index] == tag) && (state == IDLE);
    assign busywait = read && (!hit || flush_req);

    always_comb begin
        instruction = data_array[index][31:0];
        case (word)
            2'd0:    instruction = data_array[index][31:0];
            2'd1:    instruction = data_array[index][63:32];
            2'd2:    instruction = data_array[index][95:64];
            default: instruction = data_array[index][127:96];
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            valid       <= '0;
            mem_read    <= 1'b0;
            mem_address <= '0;
            miss_tag    <= '0;
            miss_index  <= '0;
`ifdef ICACHE_FLUSH_EN
            flush_pending <= 1'b0;
`endif
        end else begin
`ifdef ICACHE_FLUSH_EN
            // a flush during a refill waits for IDLE so the in-flight line is dropped too
            if (state != IDLE && flush)
                flush_pending <= 1'b1;
`endif
            case (state)
                IDLE: begin
                    if (flush_req) begin
                        valid <= '0;
`ifdef ICACHE_FLUSH_EN
                        flush_pending <= 1'b0;
`endif
                    end else if (read && !hit) begin
                        miss_tag    <= tag;
                        miss_index  <= index;
                        mem_read    <= 1'b1;
                        mem_address <= {tag, index};
                        state       <= MEM_READ;
                    end
                end
                MEM_READ: begin
                    if (!mem_busywait) begin
                        mem_read <= 1'b0;
                        state    <= UPDATE;
                    end
                end
                UPDATE: begin
                    valid[miss_index] <= 1'b1;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Arrays need no reset: valid gates every use. Reset forces IDLE, so no write survives an abort.
    always_ff @(posedge clock) begin
        if (state == UPDATE) begin
            tag_array[miss_index]  <= miss_tag;
            data_array[miss_index] <= mem_readdata;
        end
    end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Scoreboard bench for icache_direct_mapped with a latency-modelled block memory.
// Flush checks are compiled in when ICACHE_FLUSH_EN is defined.
module tb_icache_direct_mapped;
    localparam int MEM_LAT = 2;
    localparam int LIMIT   = 50;

    logic         clock = 1'b0;
    logic         reset;
    logic         read;
    logic [31:0]  address;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [27:0]  mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
`ifdef ICACHE_FLUSH_EN
    logic         flush;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int refills  = 0;
    logic [31:0] exp_q[$];

    icache_direct_mapped #(.INDEX_BITS(3)) dut (
        .clock(clock),
        .reset(reset),
        .read(read),
        .address(address),
        .instruction(instruction),
        .busywait(busywait),
        .mem_read(mem_read),
        .mem_address(mem_address),
        .mem_readdata(mem_readdata),
        .mem_busywait(mem_busywait)
`ifdef ICACHE_FLUSH_EN
        ,
        .flush(flush)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] word_of(input logic [27:0] blk, input logic [1:0] w);
        return {blk, 2'b01, w} ^ 32'hC300_0000;
    endfunction

    function automatic logic [127:0] block_of(input logic [27:0] blk);
        logic [127:0] b;
        for (int w = 0; w < 4; w++) b[32*w +: 32] = word_of(blk, 2'(w));
        return b;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // Memory model: MEM_LAT busy negedges per request, junk data until the block is released.
    initial begin
        int   lat;
        logic prev;
        lat          = MEM_LAT;
        prev         = 1'b0;
        mem_busywait = 1'b1;
        mem_readdata = '0;
        forever begin
            @(negedge clock);
            if (mem_read) begin
                if (!prev) refills++;
                if (lat == 0) begin
                    mem_busywait = 1'b0;
                    mem_readdata = block_of(mem_address);
                end else begin
                    lat--;
                    mem_busywait = 1'b1;
                    mem_readdata = ~block_of(mem_address);
                end
            end else begin
                lat          = MEM_LAT;
                mem_busywait = 1'b1;
            end
            prev = mem_read;
        end
    end

    // Called on a negedge; returns on the negedge after the instruction is consumed.
    task automatic fetch(input logic [31:0] a, input bit want_miss, input string tag);
        int cyc;
        cyc = 0;
        exp_q.push_back(word_of(a[31:4], a[3:2]));
        read    = 1'b1;
        address = a;
        #1;
        while (busywait && cyc < LIMIT) begin
            @(negedge clock);
            #1;
            cyc++;
            if (cyc == 1) begin
                check_val({tag, "_mem_read"}, 32'(mem_read), 32'd1);
                check_val({tag, "_mem_addr"}, 32'(mem_address), 32'(a[31:4]));
            end
        end
        check_val({tag, "_stall_cycles"}, cyc, want_miss ? MEM_LAT + 3 : 0);
        check_val({tag, "_instr"}, instruction, exp_q.pop_front());
        @(negedge clock);
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        #1;
        while (busywait && cyc < LIMIT) begin
            @(negedge clock);
            #1;
            cyc++;
        end
        check_val({tag, "_bounded"}, 32'(busywait), 32'd0);
        check_val({tag, "_instr"}, instruction, exp_q.pop_front());
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        read    = 1'b0;
        address = '0;
`ifdef ICACHE_FLUSH_EN
        flush   = 1'b0;
`endif
        @(negedge clock);
        #1;
        check_val("reset_mem_read", 32'(mem_read), 32'd0);
        check_val("reset_mem_addr", 32'(mem_address), 32'd0);
        check_val("reset_busywait", 32'(busywait), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // idle with a cold cache
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val("idle_busywait", 32'(busywait), 32'd0);
            @(negedge clock);
        end
        check_val("idle_refills", refills, 0);

        fetch(32'h0000_0000, 1'b1, "cold_w0");
        fetch(32'h0000_0004, 1'b0, "hit_w1");
        fetch(32'h0000_0008, 1'b0, "hit_w2");
        fetch(32'h0000_000C, 1'b0, "hit_w3");
        check_val("hits_refills", refills, 1);

        fetch(32'h0000_0080, 1'b1, "conflict_t1");
        fetch(32'h0000_0000, 1'b1, "evicted_t0");
        fetch(32'h0000_0004, 1'b0, "refilled_t0");
        fetch(32'h0000_0084, 1'b1, "evict_again");
        fetch(32'h1234_5678, 1'b1, "far_idx7");
        fetch(32'h1234_567C, 1'b0, "far_idx7_w3");
        fetch(32'h0000_0010, 1'b1, "idx1");
        fetch(32'h1234_5670, 1'b0, "far_idx7_w0");
        check_val("mix_refills", refills, 6);

        // address moves mid-miss: the refill keeps the latched line, the new address then misses
        exp_q.push_back(word_of(28'h000_0003, 2'd0));
        read    = 1'b1;
        address = 32'h0000_0020;
        @(negedge clock);
        #1;
        check_val("chg_mem_addr", 32'(mem_address), 32'h0000_0002);
        address = 32'h0000_0030;
        @(negedge clock);
        wait_done("chg_new_addr");
        fetch(32'h0000_0024, 1'b0, "chg_old_hit");
        check_val("chg_refills", refills, 8);

        // reset in the middle of a refill
        read    = 1'b1;
        address = 32'h0000_0040;
        @(negedge clock);
        #1;
        check_val("abort_pre_mem_read", 32'(mem_read), 32'd1);
        reset = 1'b1;
        #1;
        check_val("abort_mem_read", 32'(mem_read), 32'd0);
        check_val("abort_mem_addr", 32'(mem_address), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        fetch(32'h0000_0000, 1'b1, "abort_w0_cold");
        fetch(32'h0000_0040, 1'b1, "abort_refetch");
        check_val("abort_refills", refills, 11);

`ifdef ICACHE_FLUSH_EN
        fetch(32'h0000_0000, 1'b0, "fl_pre_hit");
        read  = 1'b0;
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        fetch(32'h0000_0000, 1'b1, "fl_idle_refill");

        // flush during MEM_READ: line fills, is dropped on return to IDLE, then refetched
        exp_q.push_back(word_of(28'h000_0002, 2'd0));
        read    = 1'b1;
        address = 32'h0000_0020;
        @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        wait_done("fl_deferred");
        check_val("fl_deferred_refills", refills, 14);
        fetch(32'h0000_0000, 1'b1, "fl_deferred_w0_cleared");
        fetch(32'h0000_0024, 1'b0, "fl_deferred_hit");
`endif

        read = 1'b0;
        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
